// File: rtl/rv523_pkg.sv
// Shared branch-compare definitions: FUNCT3 branch encodings, FSM state
// encoding and the branch-decision helpers used by the serial comparator.
package rv523_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    // 010 and 011 are the only encodings without a branch meaning
    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3[2:1] == 2'b01);
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       eq,
                                          input logic       lt,
                                          input logic       ltu);
        logic t;
        case (f3)
            F3_BEQ:  t = eq;
            F3_BNE:  t = ~eq;
            F3_BLT:  t = lt;
            F3_BGE:  t = ~lt;
            F3_BLTU: t = ltu;
            F3_BGEU: t = ~ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cmp_bit_slice.sv
// One LSB-first compare step: next EQ / LT / LTU accumulators from the
// current bit pair and the running accumulators.
module cmp_bit_slice (
    input  logic first,
    input  logic msb,
    input  logic rs1_bit,
    input  logic rs2_bit,
    input  logic eq_acc,
    input  logic lt_acc,
    input  logic ltu_acc,
    output logic eq_nxt,
    output logic lt_nxt,
    output logic ltu_nxt
);

    logic diff;

    assign diff = rs1_bit ^ rs2_bit;

    // On the first bit the accumulators start from EQ=1, LT=LTU=0
    assign eq_nxt  = ~diff & (first | eq_acc);
    assign ltu_nxt = diff ? rs2_bit : (~first & ltu_acc);
    // A differing sign bit decides signed order the opposite way round
    assign lt_nxt  = diff ? (msb ? rs1_bit : rs2_bit) : (~first & lt_acc);

endmodule

// File: rtl/branch_cmp_serial.sv
// Bit-serial RISC-V branch comparator: consumes rs1/rs2 LSB first, one bit
// pair per cycle, and reports the branch decision XLEN cycles after START.
module branch_cmp_serial
    import rv523_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [2:0] FUNCT3,
    input  logic       RS1_BIT,
    input  logic       RS2_BIT,
    output logic       BUSY,
    output logic       DONE,
    output logic       TAKEN,
    output logic       ILLEGAL
);

    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    f3_q;
    logic          eq_acc;
    logic          lt_acc;
    logic          ltu_acc;
    logic          eq_nxt;
    logic          lt_nxt;
    logic          ltu_nxt;
    logic          accept;
    logic          msb;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE, ST_RESULT: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt == LAST) begin
                    state_nxt = ST_RESULT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign msb = (state == ST_SHIFT) && (cnt == LAST);

    cmp_bit_slice u_slice (
        .first   (accept),
        .msb     (msb),
        .rs1_bit (RS1_BIT),
        .rs2_bit (RS2_BIT),
        .eq_acc  (eq_acc),
        .lt_acc  (lt_acc),
        .ltu_acc (ltu_acc),
        .eq_nxt  (eq_nxt),
        .lt_nxt  (lt_nxt),
        .ltu_nxt (ltu_nxt)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            f3_q    <= F3_BEQ;
            eq_acc  <= 1'b1;
            lt_acc  <= 1'b0;
            ltu_acc <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                f3_q    <= FUNCT3;
                cnt     <= CW'(1);
                eq_acc  <= eq_nxt;
                lt_acc  <= lt_nxt;
                ltu_acc <= ltu_nxt;
            end else if (state == ST_SHIFT) begin
                // Hold at the last index rather than wrapping
                if (cnt != LAST) begin
                    cnt <= cnt + CW'(1);
                end
                eq_acc  <= eq_nxt;
                lt_acc  <= lt_nxt;
                ltu_acc <= ltu_nxt;
            end
        end
    end

    assign BUSY    = (state == ST_SHIFT);
    assign DONE    = (state == ST_RESULT);
    assign TAKEN   = DONE & branch_taken(f3_q, eq_acc, lt_acc, ltu_acc);
    assign ILLEGAL = DONE & f3_illegal(f3_q);

endmodule

// File: tb/tb_branch_cmp_serial.sv
// Directed bench for branch_cmp_serial (XLEN=32): vector table plus
// back-to-back, ignored-START and mid-compare reset sequences.
module tb_branch_cmp_serial;

    localparam int XLEN = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] funct3 = 3'b000;
    logic       rs1_bit = 1'b0;
    logic       rs2_bit = 1'b0;
    logic       busy;
    logic       done;
    logic       taken;
    logic       illegal;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [2:0]  f3;
        logic        taken;
        logic        illegal;
    } vec_t;

    vec_t vecs[16];

    branch_cmp_serial #(.XLEN(XLEN)) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .START   (start),
        .FUNCT3  (funct3),
        .RS1_BIT (rs1_bit),
        .RS2_BIT (rs2_bit),
        .BUSY    (busy),
        .DONE    (done),
        .TAKEN   (taken),
        .ILLEGAL (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: presents START and bit 0 for the coming posedge
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        start   = 1'b1;
        funct3  = f;
        rs1_bit = a[0];
        rs2_bit = b[0];
    endtask

    // Drives bits 1..XLEN-1, counting cycles where BUSY/DONE are wrong;
    // returns at the negedge of the cycle where DONE is expected.
    task automatic feed(input logic [31:0] a, input logic [31:0] b,
                        input int restart_at, input logic [2:0] f3b, output int bad);
        bad = 0;
        for (int i = 1; i < XLEN; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            start   = (i == restart_at);
            funct3  = (i == restart_at) ? f3b : 3'b000;
            rs1_bit = a[i];
            rs2_bit = b[i];
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int bad;
        int gap_bad;

        vecs[0]  = '{32'h0000_1234, 32'h0000_1234, 3'b000, 1'b1, 1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b1, 1'b0};
        vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1'b0, 1'b0};
        vecs[3]  = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1'b0, 1'b0};
        vecs[4]  = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 1'b1, 1'b0};
        vecs[5]  = '{32'h0000_0005, 32'h0000_0007, 3'b001, 1'b1, 1'b0};
        vecs[6]  = '{32'h0000_0005, 32'h0000_0005, 3'b001, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000_0003, 32'h0000_0005, 3'b100, 1'b1, 1'b0};
        vecs[8]  = '{32'h0000_0005, 32'h0000_0003, 3'b100, 1'b0, 1'b0};
        vecs[9]  = '{32'h1234_5678, 32'h1234_5679, 3'b110, 1'b1, 1'b0};
        vecs[10] = '{32'h0000_AAAA, 32'h0000_AAAA, 3'b101, 1'b1, 1'b0};
        vecs[11] = '{32'h0000_0000, 32'hFFFF_FFFF, 3'b010, 1'b0, 1'b1};
        vecs[12] = '{32'h0000_0007, 32'h0000_0007, 3'b011, 1'b0, 1'b1};
        vecs[13] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b100, 1'b1, 1'b0};
        vecs[14] = '{32'h0000_0001, 32'h8000_0000, 3'b100, 1'b0, 1'b0};
        vecs[15] = '{32'h0000_0001, 32'h8000_0000, 3'b110, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {28'd0, busy, done, taken, illegal}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", {28'd0, busy, done, taken, illegal}, 32'd0);

        // Vector table
        for (int v = 0; v < 16; v++) begin
            launch(vecs[v].rs1, vecs[v].rs2, vecs[v].f3);
            feed(vecs[v].rs1, vecs[v].rs2, 0, 3'b000, bad);
            chk($sformatf("v%0d_busy_window", v), bad, 0);
            chk($sformatf("v%0d_done", v), {31'd0, done}, 32'd1);
            chk($sformatf("v%0d_taken", v), {31'd0, taken}, {31'd0, vecs[v].taken});
            chk($sformatf("v%0d_illegal", v), {31'd0, illegal}, {31'd0, vecs[v].illegal});
            chk($sformatf("v%0d_busy_in_result", v), {31'd0, busy}, 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_after_done", v), {28'd0, busy, done, taken, illegal}, 32'd0);
        end

        // Back-to-back: START held in the RESULT cycle of an illegal compare
        launch(32'h0000_0000, 32'hFFFF_FFFF, 3'b010);
        feed(32'h0000_0000, 32'hFFFF_FFFF, 0, 3'b000, bad);
        chk("b2b_first_done_illegal", {30'd0, done, illegal}, 32'd3);
        chk("b2b_first_taken", {31'd0, taken}, 32'd0);
        launch(32'h0000_1234, 32'h0000_1234, 3'b000);
        feed(32'h0000_1234, 32'h0000_1234, 0, 3'b000, bad);
        chk("b2b_second_busy_window", bad, 0);
        chk("b2b_second_done_taken", {29'd0, done, taken, illegal}, 32'd6);
        @(negedge clk);
        chk("b2b_after_done", {30'd0, busy, done}, 32'd0);

        // START during SHIFT with BNE must not disturb the in-flight BEQ
        launch(32'h0000_1234, 32'h0000_1234, 3'b000);
        feed(32'h0000_1234, 32'h0000_1234, 5, 3'b001, bad);
        chk("ignore_busy_window", bad, 0);
        chk("ignore_done_taken", {29'd0, done, taken, illegal}, 32'd6);
        @(negedge clk);
        chk("ignore_after_done", {30'd0, busy, done}, 32'd0);

        // Reset pulsed in cycle t+10 aborts; fresh START at t+15
        launch(32'h0000_1234, 32'h0000_1234, 3'b000);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            start   = 1'b0;
            rs1_bit = 1'b0;
            rs2_bit = 1'b0;
        end
        @(negedge clk);
        chk("abort_busy_before_reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs_immediate", {28'd0, busy, done, taken, illegal}, 32'd0);
        gap_bad = 0;
        for (int c = 11; c <= 14; c++) begin
            @(negedge clk);
            if (c == 11) rst_n = 1'b1;
            if (busy !== 1'b0 || done !== 1'b0) gap_bad++;
        end
        @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0) gap_bad++;
        chk("abort_no_done", gap_bad, 0);
        launch(32'h0000_0003, 32'h0000_0005, 3'b110);
        feed(32'h0000_0003, 32'h0000_0005, 0, 3'b000, bad);
        chk("abort_fresh_busy_window", bad, 0);
        chk("abort_fresh_done_taken", {29'd0, done, taken, illegal}, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_cmp_serial.md
BRANCH_CMP_SERIAL -- requirements
Module: branch_cmp_serial

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand width in bits; legal values are 8..64.
REQ-002 SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port START, input, 1 bit, requesting a new compare; bit 0 of both operands is presented in the same cycle.
REQ-005 SHALL have port FUNCT3, input, 3 bits, the branch type, sampled only in the START cycle.
REQ-006 SHALL have port RS1_BIT, input, 1 bit, the current rs1 bit (LSB first).
REQ-007 SHALL have port RS2_BIT, input, 1 bit, the current rs2 bit (LSB first).
REQ-008 SHALL have port BUSY, output, 1 bit, high while bits 1..XLEN-1 are being consumed.
REQ-009 SHALL have port DONE, output, 1 bit, a one-cycle result-valid pulse.
REQ-010 SHALL have port TAKEN, output, 1 bit, the branch decision; valid only when DONE=1.
REQ-011 SHALL have port ILLEGAL, output, 1 bit, high with DONE when the latched FUNCT3 is 010 or 011.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and RESULT.
REQ-013 IDLE + START SHALL latch FUNCT3, consume bit 0, clear the bit counter to 1 and go to SHIFT; IDLE without START holds.
REQ-014 SHIFT SHALL consume one bit pair per cycle and increment the counter; after consuming bit XLEN-1 it SHALL go to RESULT.
REQ-015 Latency: START in cycle t, bits consumed in t..t+XLEN-1, DONE=1 in cycle t+XLEN exactly.
REQ-016 RESULT SHALL drive DONE=1 for one cycle, then go to IDLE; START in the RESULT cycle SHALL be accepted as in IDLE (back-to-back, no bubble).
REQ-017 START while in SHIFT SHALL be ignored; the in-flight compare and its latched FUNCT3 SHALL be unaffected.
REQ-018 The EQ accumulator SHALL be set at bit 0 to NOT(RS1_BIT XOR RS2_BIT) and ANDed with that term for each later bit.
REQ-019 The LTU accumulator SHALL take value RS2_BIT when the bits differ and otherwise hold; its bit-0 start value is 0.
REQ-020 The signed LT result SHALL equal LTU, except when the bits at XLEN-1 differ, in which case it SHALL be RS1_BIT of bit XLEN-1.
REQ-021 TAKEN SHALL be derived from the latched FUNCT3:
- 000 gives EQ; 001 gives !EQ.
- 100 gives LT; 101 gives !LT.
- 110 gives LTU; 111 gives !LTU.
- 010 and 011 give TAKEN=0 and ILLEGAL=1.
REQ-022 TAKEN and ILLEGAL SHALL be 0 whenever DONE=0.
REQ-023 BUSY SHALL be 1 exactly in SHIFT, and 0 in IDLE and RESULT.
REQ-024 The counter SHALL be $clog2(XLEN) bits wide and SHALL NOT wrap within a compare; the counter value is don't-care in IDLE.

Reset
REQ-025 RST_N low SHALL immediately force state=IDLE, counter=0, EQ=1, LTU=0, latched FUNCT3=000, and BUSY=DONE=TAKEN=ILLEGAL=0.
REQ-026 Reset asserted mid-SHIFT SHALL abort the compare with no DONE pulse; the first START after release SHALL begin a fresh compare.
REQ-027 Deassertion of RST_N SHALL be synchronised externally; the block SHALL NOT sample START in the release cycle.

Structure
REQ-028 The FUNCT3 branch encodings and the FSM state encoding SHALL live in the shared package rv523_pkg.
REQ-029 The per-bit EQ/LTU update SHALL be one sub-module, cmp_bit_slice (combinational next-state from the current bits and accumulators); the FSM, counter and registers SHALL stay in branch_cmp_serial.
REQ-030 No operand SHALL be stored; only the accumulators, counter, FUNCT3 and state are registered.

Verification (XLEN=32)
REQ-031 rs1=rs2=0x0000_1234, FUNCT3=000 -> DONE in cycle t+32, TAKEN=1, ILLEGAL=0; BUSY high in cycles t+1..t+31.
REQ-032 rs1=0xFFFF_FFFF, rs2=0x0000_0001, FUNCT3=100 -> TAKEN=1 (signed -1<1); the same operands with FUNCT3=110 -> TAKEN=0.
REQ-033 rs1=0x8000_0000, rs2=0x7FFF_FFFF: FUNCT3=101 -> TAKEN=0; FUNCT3=111 -> TAKEN=1.
REQ-034 FUNCT3=010 with any operands -> DONE=1, ILLEGAL=1, TAKEN=0; START held high in the RESULT cycle -> next DONE exactly 32 cycles later.
REQ-035 RST_N pulsed low in cycle t+10 of a compare -> outputs 0 immediately, no DONE pulse; START at t+15 -> DONE at t+47.
REQ-036 START re-asserted in cycle t+5 with FUNCT3=001 during a BEQ of equal operands -> DONE at t+32 with TAKEN=1 (BEQ result, second START ignored).
